// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath.
// slave: controller side (op/funct/zero in, controls out); master: datapath side.
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       i_or_d;
    logic       ireg_enab;
    logic       mem_write;
    logic       pc_enab;
    logic [1:0] pc_src;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_srcA;
    logic [1:0] alu_srcB;
    logic       imm_zext;
    logic [2:0] alu_ctrl_sig;
    logic       illegal;
    logic [3:0] state_o;

    modport slave (
        input  op, funct, zero,
        output i_or_d, ireg_enab, mem_write, pc_enab, pc_src,
        output mem_to_reg, reg_dst, reg_write, alu_srcA, alu_srcB,
        output imm_zext, alu_ctrl_sig, illegal, state_o
    );

    modport master (
        output op, funct, zero,
        input  i_or_d, ireg_enab, mem_write, pc_enab, pc_src,
        input  mem_to_reg, reg_dst, reg_write, alu_srcA, alu_srcB,
        input  imm_zext, alu_ctrl_sig, illegal, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM + ALU decode, memory wait states,
// sticky illegal-op trap. Ports: clk, reset (sync, high), bus (slave modport).
module mc_ctrl_fsm #(
    parameter int unsigned MEM_LAT = 0,
    parameter bit          EXT_EN  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,  S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,  S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,  S_IMMWB   = 4'd10, S_JUMP    = 4'd11
    } state_e;

    localparam logic [3:0] LAT = 4'(MEM_LAT);
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110, A_SLT = 3'b111;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;

    logic is_lw, is_sw, is_r, is_beq, is_bne;
    logic is_addi, is_andi, is_ori, is_j;
    logic f_ok, mem_st, dwell_done;
    logic [2:0] r_alu, i_alu;

    assign is_lw   = bus.op == 6'b100011;
    assign is_sw   = bus.op == 6'b101011;
    assign is_r    = bus.op == 6'b000000;
    assign is_beq  = bus.op == 6'b000100;
    assign is_bne  = EXT_EN && bus.op == 6'b000101;
    assign is_addi = EXT_EN && bus.op == 6'b001000;
    assign is_andi = EXT_EN && bus.op == 6'b001100;
    assign is_ori  = EXT_EN && bus.op == 6'b001101;
    assign is_j    = EXT_EN && bus.op == 6'b000010;

    always_comb begin
        f_ok  = 1'b1;
        r_alu = 3'b000;
        unique case (bus.funct)
            6'b100000: r_alu = A_ADD;
            6'b100010: r_alu = A_SUB;
            6'b100100: r_alu = A_AND;
            6'b100101: r_alu = A_OR;
            6'b101010: r_alu = A_SLT;
            default:   f_ok  = 1'b0;
        endcase
    end

    assign i_alu = is_andi ? A_AND : (is_ori ? A_OR : A_ADD);

    // Only the memory states dwell; elsewhere the counter sits at zero.
    assign mem_st     = state_q == S_FETCH || state_q == S_MEMRD ||
                        state_q == S_MEMWR;
    assign dwell_done = wait_q == LAT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = 4'd0;
        illegal_d = illegal_q;
        if (mem_st && !dwell_done) begin
            wait_d = wait_q + 4'd1;
        end else begin
            unique case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        is_lw, is_sw:               state_d = S_MEMADR;
                        is_r:                       state_d = S_RTYPEEX;
                        is_beq, is_bne:             state_d = S_BRANCH;
                        is_addi, is_andi, is_ori:   state_d = S_IMMEX;
                        is_j:                       state_d = S_JUMP;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR:  state_d = is_lw ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_d = S_MEMWB;
                S_RTYPEEX: begin
                    state_d = f_ok ? S_RTYPEWB : S_FETCH;
                    if (!f_ok) illegal_d = 1'b1;
                end
                S_IMMEX:   state_d = S_IMMWB;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    logic ireg_c, memw_c, pce_c, regw_c;

    always_comb begin
        bus.i_or_d       = 1'b0;
        bus.pc_src       = 2'b00;
        bus.mem_to_reg   = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.alu_srcA     = 1'b0;
        bus.alu_srcB     = 2'b00;
        bus.imm_zext     = 1'b0;
        bus.alu_ctrl_sig = 3'b000;
        ireg_c           = 1'b0;
        memw_c           = 1'b0;
        pce_c            = 1'b0;
        regw_c           = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.alu_srcB     = 2'b01;
                bus.alu_ctrl_sig = A_ADD;
                ireg_c           = dwell_done;
                pce_c            = dwell_done;
            end
            S_DECODE: begin
                bus.alu_srcB     = 2'b11;
                bus.alu_ctrl_sig = A_ADD;
            end
            S_MEMADR: begin
                bus.alu_srcA     = 1'b1;
                bus.alu_srcB     = 2'b10;
                bus.alu_ctrl_sig = A_ADD;
            end
            S_MEMRD: bus.i_or_d = 1'b1;
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                regw_c         = 1'b1;
            end
            S_MEMWR: begin
                bus.i_or_d = 1'b1;
                memw_c     = dwell_done;
            end
            S_RTYPEEX: begin
                bus.alu_srcA     = 1'b1;
                bus.alu_ctrl_sig = r_alu;
            end
            S_RTYPEWB: begin
                bus.reg_dst = 1'b1;
                regw_c      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_srcA     = 1'b1;
                bus.alu_ctrl_sig = A_SUB;
                bus.pc_src       = 2'b01;
                pce_c            = is_beq ? bus.zero : ~bus.zero;
            end
            S_IMMEX: begin
                bus.alu_srcA     = 1'b1;
                bus.alu_srcB     = 2'b10;
                bus.alu_ctrl_sig = i_alu;
                bus.imm_zext     = is_andi | is_ori;
            end
            S_IMMWB: begin
                bus.alu_ctrl_sig = i_alu;
                bus.imm_zext     = is_andi | is_ori;
                regw_c           = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src = 2'b10;
                pce_c      = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset cycle must never commit a partial instruction.
    assign bus.ireg_enab = ireg_c & ~reset;
    assign bus.mem_write = memw_c & ~reset;
    assign bus.pc_enab   = pce_c & ~reset;
    assign bus.reg_write = regw_c & ~reset;
    assign bus.illegal   = illegal_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected output sequences are
// generated from the instruction rules and compared every cycle.
module tb_mc_ctrl_fsm;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2;
    localparam logic [3:0] MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5;
    localparam logic [3:0] RTEX = 4'd6, RTWB = 4'd7, BRANCH = 4'd8;
    localparam logic [3:0] IMMEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b110, A_SLT = 3'b111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, ireg, mw, pce;
        logic [1:0] pcs;
        logic       m2r, rdst, rw, sa;
        logic [1:0] sb;
        logic       zx;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    mc_ctrl_fsm_if if0();
    mc_ctrl_fsm_if if1();

    mc_ctrl_fsm #(.MEM_LAT(0), .EXT_EN(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0)
    );
    mc_ctrl_fsm #(.MEM_LAT(3), .EXT_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .bus(if1)
    );

    exp_t act0, act1;
    assign act0 = {if0.state_o, if0.i_or_d, if0.ireg_enab, if0.mem_write,
                   if0.pc_enab, if0.pc_src, if0.mem_to_reg, if0.reg_dst,
                   if0.reg_write, if0.alu_srcA, if0.alu_srcB, if0.imm_zext,
                   if0.alu_ctrl_sig, if0.illegal};
    assign act1 = {if1.state_o, if1.i_or_d, if1.ireg_enab, if1.mem_write,
                   if1.pc_enab, if1.pc_src, if1.mem_to_reg, if1.reg_dst,
                   if1.reg_write, if1.alu_srcA, if1.alu_srcB, if1.imm_zext,
                   if1.alu_ctrl_sig, if1.illegal};

    exp_t q0[$];
    exp_t q1[$];
    exp_t seq[$];
    logic ill_m[2];
    string tname;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input exp_t a, input exp_t e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    task automatic pin(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL pin %s: got %0d want %0d", nm, got, want);
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0) check({"d0 ", tname}, act0, q0.pop_front());
        if (q1.size() != 0) check({"d1 ", tname}, act1, q1.pop_front());
    end

    // Expected cycle-by-cycle outputs of one instruction, from the ISA rules.
    task automatic build(input int lat, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic ill_in, output logic ill_out);
        exp_t e;
        logic cur;
        logic fok;
        logic [2:0] ra;
        cur = ill_in;
        seq.delete();
        for (int k = 0; k <= lat; k++) begin
            e = '0; e.st = FETCH; e.sb = 2'b01; e.alu = A_ADD;
            e.ireg = (k == lat); e.pce = (k == lat); e.ill = cur;
            seq.push_back(e);
        end
        e = '0; e.st = DECODE; e.sb = 2'b11; e.alu = A_ADD; e.ill = cur;
        seq.push_back(e);
        case (o)
            LW, SW: begin
                e = '0; e.st = MEMADR; e.sa = 1'b1; e.sb = 2'b10;
                e.alu = A_ADD; e.ill = cur;
                seq.push_back(e);
                for (int k = 0; k <= lat; k++) begin
                    e = '0; e.st = (o == LW) ? MEMRD : MEMWR; e.iord = 1'b1;
                    e.mw = (o == SW) && (k == lat); e.ill = cur;
                    seq.push_back(e);
                end
                if (o == LW) begin
                    e = '0; e.st = MEMWB; e.m2r = 1'b1; e.rw = 1'b1; e.ill = cur;
                    seq.push_back(e);
                end
            end
            RT: begin
                fok = 1'b1;
                case (f)
                    6'b100000: ra = A_ADD;
                    6'b100010: ra = A_SUB;
                    6'b100100: ra = A_AND;
                    6'b100101: ra = A_OR;
                    6'b101010: ra = A_SLT;
                    default: begin ra = 3'b000; fok = 1'b0; end
                endcase
                e = '0; e.st = RTEX; e.sa = 1'b1; e.alu = ra; e.ill = cur;
                seq.push_back(e);
                if (fok) begin
                    e = '0; e.st = RTWB; e.rdst = 1'b1; e.rw = 1'b1; e.ill = cur;
                    seq.push_back(e);
                end else cur = 1'b1;
            end
            BEQ, BNE: begin
                e = '0; e.st = BRANCH; e.sa = 1'b1; e.alu = A_SUB; e.pcs = 2'b01;
                e.pce = (o == BEQ) ? z : !z; e.ill = cur;
                seq.push_back(e);
            end
            ADDI, ANDI, ORI: begin
                ra = (o == ANDI) ? A_AND : (o == ORI) ? A_OR : A_ADD;
                e = '0; e.st = IMMEX; e.sa = 1'b1; e.sb = 2'b10; e.alu = ra;
                e.zx = (o != ADDI); e.ill = cur;
                seq.push_back(e);
                e = '0; e.st = IMMWB; e.alu = ra; e.zx = (o != ADDI);
                e.rw = 1'b1; e.ill = cur;
                seq.push_back(e);
            end
            J: begin
                e = '0; e.st = JUMP; e.pcs = 2'b10; e.pce = 1'b1; e.ill = cur;
                seq.push_back(e);
            end
            default: cur = 1'b1;
        endcase
        ill_out = cur;
    endtask

    // cut==0: full instruction; otherwise reset is held during cycle index cut.
    task automatic run(input int d, input string nm, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input int cut);
        logic nill;
        exp_t e;
        int n;
        tname = nm;
        build(d == 0 ? 0 : 3, o, f, z, ill_m[d], nill);
        if (d == 0) begin if0.op = o; if0.funct = f; if0.zero = z; end
        else begin if1.op = o; if1.funct = f; if1.zero = z; end
        n = (cut == 0) ? seq.size() : cut;
        for (int i = 0; i < n; i++) begin
            if (d == 0) q0.push_back(seq[i]); else q1.push_back(seq[i]);
        end
        if (cut != 0) begin
            e = seq[cut];
            e.ireg = 1'b0; e.mw = 1'b0; e.pce = 1'b0; e.rw = 1'b0;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
        if (cut == 0) begin
            ill_m[d] = nill;
        end else begin
            if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
            @(posedge clk);
            #1;
            if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
            ill_m[d] = 1'b0;
        end
    endtask

    initial begin
        logic dummy;
        exp_t e;
        rst0 = 1'b1; rst1 = 1'b1;
        if0.op = LW; if0.funct = 6'd0; if0.zero = 1'b0;
        if1.op = LW; if1.funct = 6'd0; if1.zero = 1'b0;
        ill_m[0] = 1'b0; ill_m[1] = 1'b0;

        build(0, LW, 6'd0, 1'b0, 1'b0, dummy); pin("lat lw", seq.size(), 5);
        pin("lw wb state", int'(seq[4].st), 4);
        pin("lw wb rw m2r rdst", int'({seq[4].rw, seq[4].m2r, seq[4].rdst}), 6);
        build(0, SW, 6'd0, 1'b0, 1'b0, dummy); pin("lat sw", seq.size(), 4);
        build(0, RT, 6'b100000, 1'b0, 1'b0, dummy); pin("lat r", seq.size(), 4);
        build(0, ORI, 6'd0, 1'b0, 1'b0, dummy); pin("lat imm", seq.size(), 4);
        pin("ori alu zx", int'({seq[2].alu, seq[2].zx}), 3);
        build(0, BNE, 6'd0, 1'b1, 1'b0, dummy); pin("lat bne", seq.size(), 3);
        pin("bne z1 pce", int'(seq[2].pce), 0);
        build(0, J, 6'd0, 1'b0, 1'b0, dummy); pin("lat j", seq.size(), 3);
        build(0, BAD, 6'd0, 1'b0, 1'b0, dummy); pin("lat ill", seq.size(), 2);
        build(3, SW, 6'd0, 1'b0, 1'b0, dummy); pin("lat sw L3", seq.size(), 10);
        build(3, LW, 6'd0, 1'b0, 1'b0, dummy); pin("lat lw L3", seq.size(), 11);

        tname = "reset";
        @(posedge clk);
        #1;
        e = '0; e.st = FETCH; e.sb = 2'b01; e.alu = A_ADD;
        q0.push_back(e); q0.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst0 = 1'b0;

        run(0, "lw", LW, 6'd0, 1'b0, 0);
        run(0, "sw", SW, 6'd0, 1'b0, 0);
        run(0, "add", RT, 6'b100000, 1'b0, 0);
        run(0, "sub", RT, 6'b100010, 1'b0, 0);
        run(0, "and", RT, 6'b100100, 1'b0, 0);
        run(0, "or", RT, 6'b100101, 1'b0, 0);
        run(0, "slt", RT, 6'b101010, 1'b0, 0);
        run(0, "beq z1", BEQ, 6'd0, 1'b1, 0);
        run(0, "beq z0", BEQ, 6'd0, 1'b0, 0);
        run(0, "bne z1", BNE, 6'd0, 1'b1, 0);
        run(0, "bne z0", BNE, 6'd0, 1'b0, 0);
        run(0, "addi", ADDI, 6'd0, 1'b0, 0);
        run(0, "andi", ANDI, 6'd0, 1'b0, 0);
        run(0, "ori", ORI, 6'd0, 1'b0, 0);
        run(0, "j", J, 6'd0, 1'b0, 0);
        run(0, "bad op", BAD, 6'd0, 1'b0, 0);
        run(0, "lw sticky", LW, 6'd0, 1'b0, 0);
        run(0, "rst in branch", BEQ, 6'd0, 1'b1, 2);
        run(0, "bad funct", RT, 6'b000000, 1'b0, 0);
        run(0, "addi sticky", ADDI, 6'd0, 1'b0, 0);
        run(0, "rst in immwb", ADDI, 6'd0, 1'b0, 3);
        run(0, "j after rst", J, 6'd0, 1'b0, 0);

        @(posedge clk);
        #1;
        rst1 = 1'b0;
        run(1, "sw L3", SW, 6'd0, 1'b0, 0);
        run(1, "lw L3", LW, 6'd0, 1'b0, 0);
        run(1, "rst memwr c2", SW, 6'd0, 1'b0, 7);
        run(1, "sw L3 again", SW, 6'd0, 1'b0, 0);
        run(1, "rst memwr c4", SW, 6'd0, 1'b0, 9);
        run(1, "beq L3", BEQ, 6'd0, 1'b0, 0);
        run(1, "bad op L3", BAD, 6'd0, 1'b0, 0);

        @(posedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_chk++;
            $display("FAIL drain: left %0d/%0d want 0", q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
